serial_rx_param: RTL and testbench

Parametrised UART receiver with oversampled majority-vote bit recovery, configurable frame format, error reporting and an output FIFO with a valid/ready handshake. It sits between the board RX pin and any byte consumer (command decoder, loopback, display logic). It generalises the fixed 8-bit, 115200-baud receiver.

---
 rtl/serial_rx_param.sv | 260 ++++++++++++++++++++++++++
 tb/tb_serial_rx_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_param.sv
// serial_rx_param
//   UART receiver with oversampled majority-vote bit recovery, a
//   configurable frame format, error reporting and a first-word-fall-through
//   output FIFO with a valid/ready handshake.
//
// Optional feature macro: SERIAL_RX_PARITY_EN
//   defined   -> frames carry one parity bit (even, or odd when PARITY_ODD=1);
//                failed frames pulse parity_err and are not pushed.
//   undefined -> no parity bit; parity_err is constant 0.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   txd_in     asynchronous serial line, idles high
//   rx_data    FIFO head word, LSB is the first received bit
//   rx_valid   FIFO not empty
//   rx_ready   consumer takes the head word when rx_valid & rx_ready
//   frame_err  1-clk pulse: stop bit sampled low
//   parity_err 1-clk pulse: parity mismatch
//   overrun    1-clk pulse: good frame dropped because the FIFO was full
module serial_rx_param #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 txd_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int SAMPLE_RATE = BAUD * OVERSAMPLE;
  localparam int DIV_ROUND   = (CLK_HZ + SAMPLE_RATE / 2) / SAMPLE_RATE;
  localparam int DIV         = (DIV_ROUND < 1) ? 1 : DIV_ROUND;
  localparam int CW          = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW          = $clog2(OVERSAMPLE);
  localparam int BW          = $clog2(DATA_BITS);
  localparam int AW          = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] SAMP_A    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_B    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SAMP_C    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  // Reject configurations the bit-recovery and FIFO logic cannot handle.
  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8 || OVERSAMPLE > 32 ||
      DATA_BITS < 5 || DATA_BITS > 9 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("serial_rx_param: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state;
  logic                 sync1, sync2;
  logic                 line;
  logic [CW-1:0]        tick_cnt;
  logic                 tick;
  logic [SW-1:0]        samp_cnt;
  logic                 samp_a, samp_b;
  logic                 maj;
  logic                 decide, bit_end;
  logic                 enter_start;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 push, pop;
  logic                 full, empty;
  logic [AW:0]          wptr, rptr;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
`ifdef SERIAL_RX_PARITY_EN
  logic                 par_bad;
  logic                 exp_par;
`endif

  // Two-flop synchroniser; resets to the idle (high) line level so that
  // reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= txd_in;
      sync2 <= sync1;
    end
  end

  assign line        = sync2;
  assign enter_start = (state == IDLE) && !line;
  assign tick        = (tick_cnt == TICK_LAST);

  // Sample-tick divider, re-phased at every start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (enter_start || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Position within the current bit, in sample ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_cnt <= '0;
    end else if (enter_start) begin
      samp_cnt <= '0;
    end else if (tick) begin
      samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
    end
  end

  // First two of the three mid-bit votes; the third is the live line value
  // at the decision tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (tick) begin
      if (samp_cnt == SAMP_A) samp_a <= line;
      if (samp_cnt == SAMP_B) samp_b <= line;
    end
  end

  assign maj     = (samp_a & samp_b) | (samp_a & line) | (samp_b & line);
  assign decide  = tick && (samp_cnt == SAMP_C);
  assign bit_end = tick && (samp_cnt == SAMP_LAST);

`ifdef SERIAL_RX_PARITY_EN
  assign exp_par = (PARITY_ODD != 0) ? ~^shreg : ^shreg;
  assign push    = (state == STOP) && decide && maj && !par_bad;
`else
  assign push    = (state == STOP) && decide && maj;
  assign parity_err = 1'b0;
`endif

  // Frame FSM. The stop bit is acted on at its decision tick so the receiver
  // is back in IDLE before the next start edge can arrive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!line) begin
            state <= START;
`ifdef SERIAL_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end
        START: begin
          if (decide && maj) begin
            state <= IDLE;
          end else if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (decide) par_bad <= (maj != exp_par);
          if (bit_end) state <= STOP;
        end
`endif
        STOP: begin
          if (decide) begin
            if (!maj) begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end else begin
`ifdef SERIAL_RX_PARITY_EN
              if (par_bad) parity_err <= 1'b1;
`endif
              state <= IDLE;
            end
          end
        end
        WAIT_HIGH: begin
          if (line) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO status: the extra pointer bit distinguishes full from empty.
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rx_valid = !empty;
  assign pop      = rx_valid && rx_ready;
  assign rx_data  = mem[rptr[AW-1:0]];

  // Output FIFO. A simultaneous pop frees the slot a full-FIFO push needs,
  // so only a push without a pop is dropped as an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      overrun <= 1'b0;
      if (pop) rptr <= rptr + 1'b1;
      if (push) begin
        if (!full || pop) begin
          mem[wptr[AW-1:0]] <= shreg;
          wptr              <= wptr + 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_param.sv
// tb_serial_rx_param
//   Self-checking bench for serial_rx_param. A bit-level transmitter drives
//   txd_in; expected words go into a scoreboard queue as frames are sent and
//   are compared when the DUT hands them over. Error pulses are counted and
//   compared with the counts the bench expects.
//   Honours SERIAL_RX_PARITY_EN the same way the design does.
module tb_serial_rx_param;

  localparam int CLK_HZ     = 100000000;
  localparam int BAUD       = 1562500;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int PARITY_ODD = 0;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV        = 4;
  localparam int BIT        = DIV * OVERSAMPLE;
  localparam int BIT_FAST   = 62;
  localparam int BIT_SLOW   = 66;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 txd_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  int total = 0;
  int bad   = 0;
  int frame_cnt = 0, parity_cnt = 0, overrun_cnt = 0, valid_cnt = 0;
  int exp_frame = 0, exp_parity = 0, exp_overrun = 0;
  logic [DATA_BITS-1:0] exp_q [$];

  serial_rx_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS(DATA_BITS), .PARITY_ODD(PARITY_ODD), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .txd_in(txd_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Monitor on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (frame_err)  frame_cnt++;
      if (parity_err) parity_cnt++;
      if (overrun)    overrun_cnt++;
      if (rx_valid)   valid_cnt++;
      if (rx_valid && rx_ready) begin
        checkOutput("pop_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) checkOutput("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic driveBit(input logic b, input int n);
    txd_in = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

`ifdef SERIAL_RX_PARITY_EN
  function automatic logic goodPar(input logic [DATA_BITS-1:0] d);
    return (PARITY_ODD != 0) ? ~^d : ^d;
  endfunction
`endif

  task automatic sendFrame(input logic [DATA_BITS-1:0] d, input logic par_flip,
                           input logic stop, input int n);
    driveBit(1'b0, n);
    for (int i = 0; i < DATA_BITS; i++) driveBit(d[i], n);
`ifdef SERIAL_RX_PARITY_EN
    driveBit(goodPar(d) ^ par_flip, n);
`else
    if (par_flip) $display("[TB] parity flip ignored without parity bit");
`endif
    driveBit(stop, n);
  endtask

  // Good frame: the bench's own FIFO-occupancy model decides push or overrun.
  task automatic applyStimulus(input logic [DATA_BITS-1:0] d, input int n);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
    else exp_overrun++;
    sendFrame(d, 1'b0, 1'b1, n);
    driveBit(1'b1, 4);
  endtask

  task automatic waitDrain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 20 * BIT) begin
      @(posedge clk);
      k++;
    end
    #1;
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, "_frame_err"},  32'(frame_cnt),   32'(exp_frame));
    checkOutput({tag, "_parity_err"}, 32'(parity_cnt),  32'(exp_parity));
    checkOutput({tag, "_overrun"},    32'(overrun_cnt), 32'(exp_overrun));
  endtask

  initial begin
    int v0;
    rst      = 1'b1;
    txd_in   = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid",      32'(rx_valid),   32'd0);
    checkOutput("reset_data",       32'(rx_data),    32'd0);
    checkOutput("reset_frame_err",  32'(frame_err),  32'd0);
    checkOutput("reset_parity_err", 32'(parity_err), 32'd0);
    checkOutput("reset_overrun",    32'(overrun),    32'd0);
    rst = 1'b0;
    driveBit(1'b1, 2 * BIT);

    $display("[TB] basic frames");
    v0 = valid_cnt;
    applyStimulus(8'h55, BIT);
    applyStimulus(8'hA3, BIT);
    waitDrain("drain_basic");
    checkOutput("valid_cycles", 32'(valid_cnt - v0), 32'd2);
    checkCounts("basic");

    $display("[TB] start glitch");
    driveBit(1'b0, 3 * DIV);
    driveBit(1'b1, 2 * BIT);
    checkCounts("glitch");
    checkOutput("glitch_no_word", 32'(rx_valid), 32'd0);
    applyStimulus(8'h7E, BIT);
    waitDrain("drain_glitch");

    $display("[TB] framing error and break");
    sendFrame(8'h12, 1'b0, 1'b0, BIT);
    exp_frame++;
    driveBit(1'b0, 20 * BIT);
    driveBit(1'b1, 2 * BIT);
    checkCounts("break");
    checkOutput("break_no_word", 32'(rx_valid), 32'd0);
    applyStimulus(8'h34, BIT);
    waitDrain("drain_break");

    $display("[TB] baud tolerance");
    applyStimulus(8'hC9, BIT_FAST);
    applyStimulus(8'h36, BIT_SLOW);
    waitDrain("drain_rate");
    checkCounts("rate");

    $display("[TB] overrun");
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), BIT);
    checkCounts("overrun");
    checkOutput("full_valid", 32'(rx_valid), 32'd1);
    checkOutput("full_head", 32'(rx_data), 32'(exp_q[0]));
    rx_ready = 1'b1;
    waitDrain("drain_overrun");
    @(negedge clk);
    checkOutput("empty_after_drain", 32'(rx_valid), 32'd0);
    @(posedge clk);
    #1;

`ifdef SERIAL_RX_PARITY_EN
    $display("[TB] parity");
    applyStimulus(8'h07, BIT);
    waitDrain("drain_parity_ok");
    sendFrame(8'h07, 1'b1, 1'b1, BIT);
    driveBit(1'b1, 4);
    exp_parity++;
    checkCounts("parity");
    checkOutput("parity_no_word", 32'(rx_valid), 32'd0);
`endif

    $display("[TB] reset mid-frame");
    rx_ready = 1'b0;
    applyStimulus(8'h11, BIT);
    applyStimulus(8'h22, BIT);
    checkOutput("held_valid", 32'(rx_valid), 32'd1);
    checkOutput("held_head", 32'(rx_data), 32'h11);
    fork
      sendFrame(8'hC3, 1'b0, 1'b1, BIT);
      begin
        repeat (5 * BIT + BIT / 2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_valid",      32'(rx_valid),   32'd0);
        checkOutput("rst_data",       32'(rx_data),    32'd0);
        checkOutput("rst_flags",      32'({frame_err, parity_err, overrun}), 32'd0);
      end
    join
    exp_q.delete();
    driveBit(1'b1, 2);
    rst = 1'b0;
    driveBit(1'b1, 2 * BIT);
    checkOutput("post_reset_valid", 32'(rx_valid), 32'd0);
    rx_ready = 1'b1;
    applyStimulus(8'h5A, BIT);
    waitDrain("drain_after_reset");
    checkCounts("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
